maxpool_layer_0: RTL and testbench
==================================

Name: maxpool_layer_0

Overview:
- 2x2, stride-2 max-pool stage directly downstream of the first convolution layer.
- Consumes convolved feature-map rows for all kernels in parallel, one row per handshake.
- Buffers each even row and, on arrival of the following odd row, emits one pooled row per channel.
- Output feeds the next convolution layer's row input.

Parameters:
- DATA_WIDTH, 16, width of each signed fixed-point sample.
- NUM_CHANNELS, 4, number of feature maps processed in parallel (one per conv kernel).
- IN_COLS, 24, samples per input row per channel.
- IN_ROWS, 24, input rows per frame.
- OUT_COLS, IN_COLS/2 (floor), derived; pooled samples per output row.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  arms the block for one frame; sampled in IDLE only.
- in_valid  in  1  input row present.
- in_ready  out  1  block can accept an input row.
- in_row  in  DATA_WIDTH x (NUM_CHANNELS*IN_COLS)  unpacked array; channel c occupies [c*IN_COLS +: IN_COLS].
- out_valid  out  1  pooled row present.
- out_ready  in  1  consumer accepts the pooled row.
- out_row  out  DATA_WIDTH x (NUM_CHANNELS*OUT_COLS)  unpacked array; channel c occupies [c*OUT_COLS +: OUT_COLS].
- done  out  1  frame complete; level signal.

Behaviour:
- Reset (async, any state, including mid-frame):
  - state=IDLE; in_ready=0, out_valid=0, done=0.
  - out_row and row buffer all zero; row counter=0.
- States and transitions:
  - IDLE: start=1 -> clear done and row counter, go to WAIT_EVEN.
  - WAIT_EVEN: in_ready=1. Accept (in_valid&in_ready) -> latch in_row into row buffer, row_cnt+1, go to WAIT_ODD.
  - WAIT_ODD: in_ready=1. Accept -> register out_row, row_cnt+1, go to EMIT. Pooling for channel c, column j = signed max of buf[2j], buf[2j+1], in[2j], in[2j+1].
  - EMIT: out_valid=1, in_ready=0. out_row is held stable until out_valid&out_ready. On that transfer:
    - row_cnt < 2*(IN_ROWS/2) -> WAIT_EVEN.
    - otherwise, if IN_ROWS is odd -> DRAIN; else -> FINISH.
  - DRAIN: in_ready=1. Accept and discard one row, then go to FINISH.
  - FINISH: done=1 from this cycle; next cycle go to IDLE. done stays high in IDLE until the next accepted start.
- Latency and throughput:
  - out_valid rises on the cycle after the odd row is accepted.
  - Peak rate is one output row per 3 cycles: even accept, odd accept, emit.
- Arithmetic:
  - Comparisons are two's-complement signed at DATA_WIDTH.
  - No rounding, no width growth; the output sample is bit-exact to one of the four inputs.
- Boundaries:
  - IN_COLS odd: the last column is ignored.
  - start outside IDLE is ignored.
  - in_valid in IDLE, EMIT or FINISH is not accepted (in_ready=0); data is not consumed.
  - out_ready while out_valid=0 has no effect.
  - out_ready held low: the block stalls in EMIT indefinitely with out_row stable.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- Defined: each pooled sample is clamped at zero after the max, before it is registered (negative results become 0). This fuses ReLU into the stage.
- Undefined: raw signed max is output; negative values pass through.

Test Plan:
- Basic pool: channel 0 even row cols0-1 = {3,-7}, odd row cols0-1 = {5,2} -> out_row[0]=5 one cycle after the odd accept.
- All-negative signed case: four inputs {-1,-8,-3,-2} -> out=-1 (0x FFFF). With MAXPOOL_RELU_EN defined -> out=0.
- Backpressure: hold out_ready=0 for 10 cycles in EMIT -> out_valid stays 1, out_row unchanged, in_ready=0; release -> single transfer, return to WAIT_EVEN.
- Full frame, IN_ROWS=24: 24 rows streamed back-to-back -> exactly 12 out transfers; done rises after the 12th transfer and stays high until next start.
- Odd geometry, IN_ROWS=5, IN_COLS=5: 2 out transfers, 5th row consumed in DRAIN; column 4 never affects any output; then done=1.
- Async reset after 7 rows accepted -> outputs cleared immediately, state IDLE; a fresh start plus frame yields correct results with no stale buffer data.

Source files
------------

// File: rtl/maxpool_layer_0.sv
// rtl/maxpool_layer_0.sv - 2x2 stride-2 max-pool over parallel channel rows; define MAXPOOL_RELU_EN to fuse ReLU
module maxpool_layer_0 #(
   parameter int DATA_WIDTH   = 16,
   parameter int NUM_CHANNELS = 4,
   parameter int IN_COLS      = 24,
   parameter int IN_ROWS      = 24,
   localparam int OUT_COLS    = IN_COLS / 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_row  [NUM_CHANNELS*IN_COLS],
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_row [NUM_CHANNELS*OUT_COLS],
   output logic                         done
);

   localparam int CNT_W     = $clog2(IN_ROWS + 1);
   // Rows that belong to complete even/odd pairs; a trailing odd row is drained.
   localparam int PAIR_ROWS = 2 * (IN_ROWS / 2);

   typedef enum logic [2:0] {IDLE, WAIT_EVEN, WAIT_ODD, EMIT, DRAIN, FINISH} state_t;

   state_t                        state;
   state_t                        state_n;
   logic [CNT_W-1:0]              row_cnt;
   logic                          done_q;
   logic                          accept;
   logic signed [DATA_WIDTH-1:0]  row_buf [NUM_CHANNELS*IN_COLS];
   logic signed [DATA_WIDTH-1:0]  pooled  [NUM_CHANNELS*OUT_COLS];

   assign accept = in_valid & in_ready;
   assign done   = done_q;

   function automatic logic signed [DATA_WIDTH-1:0] smax(input logic signed [DATA_WIDTH-1:0] a,
                                                         input logic signed [DATA_WIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         IDLE:      if (start)  state_n = WAIT_EVEN;
         WAIT_EVEN: if (accept) state_n = WAIT_ODD;
         WAIT_ODD:  if (accept) state_n = EMIT;
         EMIT: begin
            if (out_ready) begin
               if (row_cnt < CNT_W'(PAIR_ROWS)) state_n = WAIT_EVEN;
               else if ((IN_ROWS % 2) != 0)     state_n = DRAIN;
               else                             state_n = FINISH;
            end
         end
         DRAIN:     if (accept) state_n = FINISH;
         FINISH:    state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         WAIT_EVEN, WAIT_ODD, DRAIN: in_ready  = 1'b1;
         EMIT:                       out_valid = 1'b1;
         default: ;
      endcase
   end

   // 2x2 window max per channel/column; an odd trailing column is never indexed
   always_comb begin
      logic signed [DATA_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_CHANNELS * OUT_COLS; i++) pooled[i] = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         for (int j = 0; j < OUT_COLS; j++) begin
            m = smax(smax(row_buf[c*IN_COLS + 2*j], row_buf[c*IN_COLS + 2*j + 1]),
                     smax(in_row[c*IN_COLS + 2*j],  in_row[c*IN_COLS + 2*j + 1]));
`ifdef MAXPOOL_RELU_EN
            pooled[c*OUT_COLS + j] = m[DATA_WIDTH-1] ? '0 : m;
`else
            pooled[c*OUT_COLS + j] = m;
`endif
         end
      end
   end

   // Row counter, done flag, even-row buffer and registered pooled output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_cnt <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < NUM_CHANNELS * IN_COLS; i++)  row_buf[i] <= '0;
         for (int i = 0; i < NUM_CHANNELS * OUT_COLS; i++) out_row[i] <= '0;
      end else begin
         if (state == IDLE && start) begin
            row_cnt <= '0;
            done_q  <= 1'b0;
         end else if (accept) begin
            row_cnt <= row_cnt + CNT_W'(1);
         end
         // done is visible during FINISH and held through IDLE until the next start
         if (state_n == FINISH) done_q <= 1'b1;
         if (state == WAIT_EVEN && accept) row_buf <= in_row;
         if (state == WAIT_ODD && accept)  out_row <= pooled;
      end
   end

endmodule

// File: tb/tb_maxpool_layer_0.sv
// tb/tb_maxpool_layer_0.sv - directed table-driven bench for maxpool_layer_0
module tb_maxpool_layer_0;
   localparam int DW = 16;
   localparam int NC = 4;
   localparam int IC = 24;
   localparam int IR = 24;
   localparam int OC = 12;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic start, in_valid, in_ready, out_valid, out_ready, done;
   logic signed [DW-1:0] in_row  [NC*IC];
   logic signed [DW-1:0] out_row [NC*OC];

   logic o_start, o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_done;
   logic signed [DW-1:0] o_in_row  [5];
   logic signed [DW-1:0] o_out_row [2];

   int checks = 0;
   int failures = 0;
   int xfers = 0;
   bit mon_en = 1'b0;

   maxpool_layer_0 #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .IN_COLS(IC), .IN_ROWS(IR)) u_dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_row(in_row), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .done(done)
   );

   maxpool_layer_0 #(.DATA_WIDTH(DW), .NUM_CHANNELS(1), .IN_COLS(5), .IN_ROWS(5)) u_odd (
      .clk(clk), .rst(rst), .start(o_start), .in_valid(o_in_valid), .in_ready(o_in_ready),
      .in_row(o_in_row), .out_valid(o_out_valid), .out_ready(o_out_ready), .out_row(o_out_row),
      .done(o_done)
   );

   typedef struct {
      int ch;
      int col;
      int a;
      int b;
      int c;
      int d;
      int exp;
   } vec_t;
   vec_t vecs [6];

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=handshake", name);
   endtask

   task automatic fill_full(input int r);
      for (int k = 0; k < NC*IC; k++) in_row[k] = DW'(-(r*100) - k);
   endtask

   task automatic clear_row();
      for (int k = 0; k < NC*IC; k++) in_row[k] = '0;
   endtask

   // Called at a negedge; returns at the negedge after the row was accepted.
   task automatic send_row();
      int n;
      n = 0;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) timeout("send_row");
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic recv();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) timeout("recv");
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic o_send_row(input int r);
      int n;
      n = 0;
      for (int k = 0; k < 4; k++) o_in_row[k] = DW'(r*10 + k);
      o_in_row[4] = 16'sd30000;
      o_in_valid = 1'b1;
      while (!o_in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) timeout("o_send_row");
      @(negedge clk);
      o_in_valid = 1'b0;
   endtask

   task automatic o_recv();
      int n;
      n = 0;
      o_out_ready = 1'b1;
      while (!o_out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) timeout("o_recv");
      @(negedge clk);
      o_out_ready = 1'b0;
   endtask

   // Counts transfers just after each negedge, when both drives and DUT outputs are settled
   always @(negedge clk) begin
      #1;
      if (out_valid && out_ready) begin
         if (mon_en) begin
            int bad;
            bad = 0;
            for (int k = 0; k < NC*OC; k++)
               if (out_row[k] !== DW'(-(200*xfers) - ((k/OC)*IC + 2*(k%OC)))) bad++;
            check("full_frame_row_errors", bad, 0);
         end
         xfers++;
      end
   end

   initial begin
      int x0;
      int bad;
      logic signed [DW-1:0] held;

      vecs[0] = '{ch:0, col:0,  a:3,      b:-7,     c:5,      d:2,      exp:5};
      vecs[1] = '{ch:1, col:3,  a:-1,     b:-8,     c:-3,     d:-2,     exp:-1};
      vecs[2] = '{ch:2, col:11, a:32767,  b:-32768, c:0,      d:1,      exp:32767};
      vecs[3] = '{ch:3, col:5,  a:-32768, b:-32768, c:-32768, d:-32768, exp:-32768};
      vecs[4] = '{ch:0, col:7,  a:10,     b:20,     c:30,     d:40,     exp:40};
      vecs[5] = '{ch:3, col:11, a:-5,     b:100,    c:-200,   d:99,     exp:100};

      rst = 1'b1;
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      o_start = 1'b0; o_in_valid = 1'b0; o_out_ready = 1'b0;
      clear_row();
      for (int k = 0; k < 5; k++) o_in_row[k] = '0;
      repeat (2) @(negedge clk);
      check("reset_in_ready", in_ready, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_done", done, 0);
      check("reset_out_row0", out_row[0], 0);
      rst = 1'b0;

      // in_valid in IDLE is not accepted
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_in_ready", in_ready, 0);
      in_valid = 1'b0;

      // Frame 1: 24 rows back-to-back with consumer always ready
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mon_en = 1'b1;
      out_ready = 1'b1;
      for (int r = 0; r < IR; r++) begin
         fill_full(r);
         send_row();
      end
      @(negedge clk);
      check("frame1_done", done, 1);
      check("frame1_xfers", xfers, 12);
      mon_en = 1'b0;
      out_ready = 1'b0;
      repeat (4) @(negedge clk);
      check("done_held_idle", done, 1);
      check("idle_after_done_in_ready", in_ready, 0);

      // Frame 2: start clears done
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_clears_done", done, 0);
      check("start_in_ready", in_ready, 1);

      for (int i = 0; i < 6; i++) begin
         clear_row();
         in_row[vecs[i].ch*IC + 2*vecs[i].col]     = DW'(vecs[i].a);
         in_row[vecs[i].ch*IC + 2*vecs[i].col + 1] = DW'(vecs[i].b);
         send_row();
         clear_row();
         in_row[vecs[i].ch*IC + 2*vecs[i].col]     = DW'(vecs[i].c);
         in_row[vecs[i].ch*IC + 2*vecs[i].col + 1] = DW'(vecs[i].d);
         send_row();
         check($sformatf("vec%0d_out_valid", i), out_valid, 1);
         check($sformatf("vec%0d_out", i), out_row[vecs[i].ch*OC + vecs[i].col], vecs[i].exp);
         bad = 0;
         for (int k = 0; k < NC*OC; k++)
            if (k != vecs[i].ch*OC + vecs[i].col && out_row[k] !== '0) bad++;
         check($sformatf("vec%0d_others_zero", i), bad, 0);
         recv();
         check($sformatf("vec%0d_after_xfer_valid", i), out_valid, 0);
      end

      // Backpressure: stall 10 cycles in EMIT; start and in_valid ignored meanwhile
      clear_row();
      in_row[0] = 16'sd77;
      send_row();
      clear_row();
      send_row();
      held = out_row[0];
      check("bp_out_value", held, 77);
      start = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < IC; k++) in_row[k] = 16'sd999;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_stable", out_row[0], 77);
      end
      start = 1'b0;
      in_valid = 1'b0;
      x0 = xfers;
      recv();
      check("bp_single_xfer", xfers, x0 + 1);
      check("bp_out_valid_low", out_valid, 0);
      check("bp_back_to_wait_even", in_ready, 1);

      // Remaining 10 rows of frame 2
      clear_row();
      for (int p = 0; p < 5; p++) begin
         send_row();
         send_row();
         recv();
      end
      check("frame2_done", done, 1);

      // Frame 3: async reset after 7 rows accepted
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b1;
      for (int r = 0; r < 7; r++) begin
         fill_full(r + 3);
         send_row();
      end
      out_ready = 1'b0;
      check("pre_reset_out_nonzero", (out_row[0] != 0), 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_out_row0", out_row[0], 0);
      check("async_rst_out_row47", out_row[NC*OC-1], 0);
      check("async_rst_in_ready", in_ready, 0);
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < NC*IC; k++) in_row[k] = -16'sd500;
      send_row();
      for (int k = 0; k < NC*IC; k++) in_row[k] = -16'sd400;
      send_row();
      bad = 0;
      for (int k = 0; k < NC*OC; k++) if (out_row[k] !== -16'sd400) bad++;
      check("post_reset_frame_errors", bad, 0);
      recv();

      // Odd geometry: 5x5, one channel
      o_start = 1'b1;
      @(negedge clk);
      o_start = 1'b0;
      o_send_row(0);
      o_send_row(1);
      check("odd_p0_valid", o_out_valid, 1);
      check("odd_p0_c0", o_out_row[0], 11);
      check("odd_p0_c1", o_out_row[1], 13);
      o_recv();
      o_send_row(2);
      o_send_row(3);
      check("odd_p1_c0", o_out_row[0], 31);
      check("odd_p1_c1", o_out_row[1], 33);
      o_recv();
      check("odd_drain_in_ready", o_in_ready, 1);
      check("odd_drain_done", o_done, 0);
      o_send_row(4);
      check("odd_done", o_done, 1);
      check("odd_no_third_out", o_out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end
endmodule
